// File: rtl/vjtag_pkg.sv
// Shared types and default geometry for the virtual JTAG scan master.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vjtag_pkg;

    localparam int DR_WIDTH_DEFAULT = 38;
    localparam int IR_WIDTH_DEFAULT = 2;

    typedef enum logic [2:0] {
        IDLE,
        UIR,
        CDR,
        SDR,
        UDR,
        RTI,
        DONE
    } state_t;

endpackage

// File: rtl/vjtag_scan_master_if.sv
// Command/response handshake plus the vji_* virtual TAP link in one bundle.
// Latency: n/a (wiring only).
// Backpressure: cmd_valid/cmd_ready; rsp_valid is a pulse with no ready.
interface vjtag_scan_master_if
    import vjtag_pkg::*;
#(
    parameter int DR_WIDTH = DR_WIDTH_DEFAULT,
    parameter int IR_WIDTH = IR_WIDTH_DEFAULT
) ();

    logic                cmd_valid;
    logic                cmd_ready;
    logic [IR_WIDTH-1:0] cmd_ir;
    logic [DR_WIDTH-1:0] cmd_dr;
    logic                rsp_valid;
    logic [DR_WIDTH-1:0] rsp_dr;
    logic [IR_WIDTH-1:0] rsp_ir_out;
    logic                vji_tck;
    logic                vji_tdi;
    logic                vji_tdo;
    logic [IR_WIDTH-1:0] vji_ir_in;
    logic [IR_WIDTH-1:0] vji_ir_out;
    logic                vji_uir;
    logic                vji_cdr;
    logic                vji_sdr;
    logic                vji_udr;
    logic                vji_rti;

    modport master (
        input  cmd_valid, cmd_ir, cmd_dr, vji_tdo, vji_ir_out,
        output cmd_ready, rsp_valid, rsp_dr, rsp_ir_out,
        output vji_tck, vji_tdi, vji_ir_in,
        output vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti
    );

    modport slave (
        output cmd_valid, cmd_ir, cmd_dr, vji_tdo, vji_ir_out,
        input  cmd_ready, rsp_valid, rsp_dr, rsp_ir_out,
        input  vji_tck, vji_tdi, vji_ir_in,
        input  vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti
    );

endinterface

// File: rtl/vjtag_tck_gen.sv
// Divides clk into a tck of 2*TCK_DIV cycles (low half first) with slot pulses.
// Latency: tck is registered; pulses are asserted the cycle before the edge they announce.
// Backpressure: none; counter is held at zero and tck low while en is low.
module vjtag_tck_gen #(
    parameter int TCK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    output logic tck,
    output logic slot_start,
    output logic rise
);

    localparam int            CW   = $clog2(2 * TCK_DIV);
    localparam logic [CW-1:0] LAST = CW'(2 * TCK_DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(TCK_DIV - 1);

    logic [CW-1:0] cnt;

    // The clock edge closing a pulsed cycle is the one that moves tck.
    assign slot_start = en && (cnt == LAST);
    assign rise       = en && (cnt == HALF);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
            tck <= 1'b0;
        end else if (!en) begin
            cnt <= '0;
            tck <= 1'b0;
        end else begin
            cnt <= slot_start ? '0 : cnt + 1'b1;
            if (rise)
                tck <= 1'b1;
            else if (slot_start)
                tck <= 1'b0;
        end
    end

endmodule

// File: rtl/vjtag_scan_master.sv
// Runs one UIR/CDR/SDR/UDR/RTI virtual JTAG scan per accepted command.
// Latency: rsp_valid pulses (DR_WIDTH+4)*2*TCK_DIV+1 cycles after acceptance.
// Backpressure: cmd_ready only in IDLE; a command offered while busy is held off.
module vjtag_scan_master
    import vjtag_pkg::*;
#(
    parameter int DR_WIDTH = DR_WIDTH_DEFAULT,
    parameter int IR_WIDTH = IR_WIDTH_DEFAULT,
    parameter int TCK_DIV  = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    vjtag_scan_master_if.master  bus
);

    localparam int            SW        = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
    localparam logic [SW-1:0] SLOT_LAST = SW'(DR_WIDTH - 1);

    state_t              state, state_nxt;
    logic [SW-1:0]       slot_cnt;
    logic [DR_WIDTH-1:0] tx_sr;
    logic [DR_WIDTH-1:0] rx_sr;
    logic [DR_WIDTH-1:0] rsp_dr_q;
    logic [IR_WIDTH-1:0] rsp_ir_q;
    logic [IR_WIDTH-1:0] ir_q;
    logic                busy;
    logic                slot_start;
    logic                rise;

    assign busy = (state != IDLE) && (state != DONE);

    vjtag_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck_gen (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (busy),
        .tck        (bus.vji_tck),
        .slot_start (slot_start),
        .rise       (rise)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.cmd_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.vji_tdi   = 1'b0;
        bus.vji_uir   = 1'b0;
        bus.vji_cdr   = 1'b0;
        bus.vji_sdr   = 1'b0;
        bus.vji_udr   = 1'b0;
        bus.vji_rti   = 1'b0;
        case (state)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                bus.vji_rti   = 1'b1;
                if (bus.cmd_valid) state_nxt = UIR;
            end
            UIR: begin
                bus.vji_uir = 1'b1;
                if (slot_start) state_nxt = CDR;
            end
            CDR: begin
                bus.vji_cdr = 1'b1;
                if (slot_start) state_nxt = SDR;
            end
            SDR: begin
                bus.vji_sdr = 1'b1;
                bus.vji_tdi = tx_sr[0];
                if (slot_start && (slot_cnt == SLOT_LAST)) state_nxt = UDR;
            end
            UDR: begin
                bus.vji_udr = 1'b1;
                if (slot_start) state_nxt = RTI;
            end
            RTI: begin
                bus.vji_rti = 1'b1;
                if (slot_start) state_nxt = DONE;
            end
            DONE: begin
                bus.vji_rti   = 1'b1;
                bus.rsp_valid = 1'b1;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // TDO is sampled on the clk edge that raises tck, before the responder reacts to it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_cnt <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            rsp_dr_q <= '0;
            rsp_ir_q <= '0;
            ir_q     <= '0;
        end else begin
            if ((state == IDLE) && bus.cmd_valid) begin
                tx_sr <= bus.cmd_dr;
                ir_q  <= bus.cmd_ir;
            end
            if ((state == SDR) && rise)
                rx_sr <= {bus.vji_tdo, rx_sr[DR_WIDTH-1:1]};
            if ((state == SDR) && slot_start) begin
                tx_sr    <= tx_sr >> 1;
                slot_cnt <= (slot_cnt == SLOT_LAST) ? '0 : slot_cnt + 1'b1;
            end
            if ((state == CDR) && slot_start)
                rsp_ir_q <= bus.vji_ir_out;
            if ((state == RTI) && slot_start)
                rsp_dr_q <= rx_sr;
        end
    end

    assign bus.vji_ir_in  = ir_q;
    assign bus.rsp_dr     = rsp_dr_q;
    assign bus.rsp_ir_out = rsp_ir_q;

endmodule

// File: tb/tb_vjtag_scan_master.sv
// Scoreboard bench: stimulus queues expected responses, a negedge monitor checks them.
module tb_vjtag_scan_master;
    import vjtag_pkg::*;

    localparam int DRW      = 38;
    localparam int IRW      = 2;
    localparam int DIV      = 4;
    localparam int SCAN_CYC = (DRW + 4) * 2 * DIV + 1;

    typedef struct {
        logic [DRW-1:0] dr;
        logic [IRW-1:0] ir;
        logic [IRW-1:0] ir_out;
        logic [DRW-1:0] rsp;
    } exp_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic tdo_q   = 1'b0;
    logic prev_tck = 1'b0;
    logic [IRW-1:0] cur_ir_out = '0;
    logic [4:0] exp_v;
    logic       exp_tck;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_rsp = 0;
    int rise_cnt = 0;
    int strobe_bad = 0;
    int rel, slot, ph;
    int acc_q[$];
    int acc_log[$];
    exp_t exp_q[$];

    always #5 clk = ~clk;

    vjtag_scan_master_if #(.DR_WIDTH(DRW), .IR_WIDTH(IRW)) bus ();

    vjtag_scan_master #(.DR_WIDTH(DRW), .IR_WIDTH(IRW), .TCK_DIV(DIV)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Responder: tdo follows tdi one rising tck late; ir_out is valid only during CDR.
    always @(posedge bus.vji_tck or negedge reset_n) begin
        if (!reset_n) tdo_q <= 1'b0;
        else          tdo_q <= bus.vji_tdi;
    end
    assign bus.vji_tdo    = tdo_q;
    assign bus.vji_ir_out = bus.vji_cdr ? cur_ir_out : 2'b11;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Monitor: per-cycle strobe/tck/tdi/ir_in sequence, then response pop and compare.
    always @(negedge clk) begin
        if (!reset_n) begin
            acc_q.delete();
            prev_tck = 1'b0;
        end else begin
            if (bus.vji_tck && !prev_tck) rise_cnt++;
            prev_tck = bus.vji_tck;
            if (acc_q.size() > 0 && exp_q.size() > 0) begin
                rel = cyc - acc_q[0];
                if (rel >= 1 && rel <= SCAN_CYC) begin
                    slot    = (rel - 1) / (2 * DIV);
                    ph      = (rel - 1) % (2 * DIV);
                    exp_v   = 5'b00001;
                    exp_tck = 1'b0;
                    if (rel < SCAN_CYC) begin
                        exp_tck = (ph >= DIV);
                        if (slot == 0)             exp_v = 5'b10000;
                        else if (slot == 1)        exp_v = 5'b01000;
                        else if (slot <= DRW + 1)  exp_v = 5'b00100;
                        else if (slot == DRW + 2)  exp_v = 5'b00010;
                    end
                    if ({bus.vji_uir, bus.vji_cdr, bus.vji_sdr, bus.vji_udr, bus.vji_rti} !== exp_v ||
                        bus.vji_tck !== exp_tck || bus.vji_ir_in !== exp_q[0].ir)
                        strobe_bad++;
                    if (exp_v == 5'b00100 && bus.vji_tdi !== exp_q[0].dr[slot-2])
                        strobe_bad++;
                end
            end
            if (bus.rsp_valid) begin
                n_rsp++;
                if (exp_q.size() == 0 || acc_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: rsp_valid=1 with rsp_dr=%0h, required no response", bus.rsp_dr);
                end else begin
                    exp_t e;
                    int   a;
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    chk("rsp_dr", 64'(bus.rsp_dr), 64'(e.rsp));
                    chk("rsp_ir_out", 64'(bus.rsp_ir_out), 64'(e.ir_out));
                    chk("rsp_latency", 64'(cyc - a), 64'(SCAN_CYC));
                    chk("tck_rises", 64'(rise_cnt), 64'(DRW + 4));
                    chk("strobe_seq_bad_cycles", 64'(strobe_bad), 64'd0);
                end
            end
            if (bus.cmd_valid && bus.cmd_ready) begin
                acc_q.push_back(cyc);
                acc_log.push_back(cyc);
                rise_cnt   = 0;
                strobe_bad = 0;
            end
        end
    end

    task automatic chk_reset_values(input string tag);
        chk({tag, "_cmd_ready"},  64'(bus.cmd_ready),  64'd1);
        chk({tag, "_rsp_valid"},  64'(bus.rsp_valid),  64'd0);
        chk({tag, "_rsp_dr"},     64'(bus.rsp_dr),     64'd0);
        chk({tag, "_rsp_ir_out"}, 64'(bus.rsp_ir_out), 64'd0);
        chk({tag, "_tck"},        64'(bus.vji_tck),    64'd0);
        chk({tag, "_tdi"},        64'(bus.vji_tdi),    64'd0);
        chk({tag, "_ir_in"},      64'(bus.vji_ir_in),  64'd0);
        chk({tag, "_strobes"},
            64'({bus.vji_uir, bus.vji_cdr, bus.vji_sdr, bus.vji_udr, bus.vji_rti}), 64'b00001);
    endtask

    task automatic wait_ready();
        int i;
        i = 0;
        while (!bus.cmd_ready && i < 1000) begin
            @(negedge clk);
            i++;
        end
        if (!bus.cmd_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL cmd_ready_wait: ready=0 after %0d cycles, required 1", i);
        end
    endtask

    task automatic push_exp(input logic [IRW-1:0] ir, input logic [DRW-1:0] dr,
                            input logic [IRW-1:0] ir_out, input logic [DRW-1:0] rsp);
        exp_t e;
        e.dr = dr; e.ir = ir; e.ir_out = ir_out; e.rsp = rsp;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [IRW-1:0] ir, input logic [DRW-1:0] dr,
                        input logic [IRW-1:0] ir_out, input logic [DRW-1:0] rsp);
        @(negedge clk);
        cur_ir_out = ir_out;
        push_exp(ir, dr, ir_out, rsp);
        bus.cmd_ir    = ir;
        bus.cmd_dr    = dr;
        bus.cmd_valid = 1'b1;
        wait_ready();
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_ir    = ~ir;
        bus.cmd_dr    = ~dr;
    endtask

    task automatic drain();
        for (int i = 0; i < 1000 && exp_q.size() > 0; i++) @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int base, n0;
        bus.cmd_valid = 1'b0;
        bus.cmd_ir    = '0;
        bus.cmd_dr    = '0;

        repeat (3) @(negedge clk);
        chk_reset_values("reset");
        #2 reset_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_tck_rti_ready_rsp",
                64'({bus.vji_tck, bus.vji_rti, bus.cmd_ready, bus.rsp_valid}), 64'b0110);
        end

        // Loopback responder: captured word is the input shifted up one, bit 0 = 0.
        send(2'b01, 38'h2A_5A5A_5A5A, 2'b10, 38'h14_B4B4_B4B4);
        drain();

        // Second command appears on the held inputs in cycle 5 and must wait for cycle 338.
        base = acc_log.size();
        @(negedge clk);
        cur_ir_out = 2'b10;
        push_exp(2'b10, 38'h00_FFFF_0001, 2'b10, 38'h01_FFFE_0002);
        bus.cmd_ir    = 2'b10;
        bus.cmd_dr    = 38'h00_FFFF_0001;
        bus.cmd_valid = 1'b1;
        wait_ready();
        @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        push_exp(2'b11, 38'h3C_1234_5678, 2'b10, 38'h38_2468_ACF0);
        bus.cmd_ir = 2'b11;
        bus.cmd_dr = 38'h3C_1234_5678;
        for (int i = 0; i < 800 && acc_log.size() < base + 2; i++) @(negedge clk);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        if (acc_log.size() >= base + 2)
            chk("b2b_accept_cycle", 64'(acc_log[base+1] - acc_log[base]), 64'(SCAN_CYC + 1));
        else
            chk("b2b_accept_seen", 64'(acc_log.size() - base), 64'd2);
        drain();

        // Abort in SDR slot 10: outputs clear without a clock, and no response follows.
        send(2'b01, 38'h15_5555_5555, 2'b10, 38'h2A_AAAA_AAAA);
        repeat (99) @(negedge clk);
        chk("sdr_before_abort", 64'(bus.vji_sdr), 64'd1);
        #2 reset_n = 1'b0;
        #1 chk_reset_values("abort");
        exp_q.delete();
        n0 = n_rsp;
        @(negedge clk);
        #2 reset_n = 1'b1;
        repeat (350) @(negedge clk);
        chk("no_rsp_after_abort", 64'(n_rsp), 64'(n0));

        send(2'b11, 38'h3F_0F0F_F0F0, 2'b01, 38'h3E_1E1F_E1E0);
        drain();
        chk("ir_in_held_after_scan", 64'(bus.vji_ir_in), 64'b11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/vjtag_scan_master.md
# vjtag_scan_master

Initiator end of the 2-bit-IR virtual JTAG link used by the Nios II debug module: it accepts one scan command (IR value plus DR word) on the `clk` domain and drives the `vji_*` strobes, `tck` and `tdi` that the debug module's TCK-side logic consumes. It captures `tdo` into a response word. It replaces the hardware SLD hub in simulation benches and in the on-chip debug-master path, so the debug module can be exercised without a physical JTAG cable.

## Interface
Parameters:
- `DR_WIDTH`, 38: scan-chain length in bits; legal range is 2 or more.
- `IR_WIDTH`, 2: virtual IR width.
- `TCK_DIV`, 4: `clk` cycles per `tck` half-period; legal range is 2 or more.

Ports:
- `clk`, input, 1: system clock. One clock only.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `cmd_valid`, input, 1: a scan command is offered.
- `cmd_ready`, output, 1: idle and able to accept a command.
- `cmd_ir`, input, IR_WIDTH: IR value to load.
- `cmd_dr`, input, DR_WIDTH: DR word to shift in, LSB first.
- `rsp_valid`, output, 1: one-cycle pulse when the scan completes.
- `rsp_dr`, output, DR_WIDTH: captured TDO word, LSB first. Held until the next `rsp_valid`.
- `rsp_ir_out`, output, IR_WIDTH: `vji_ir_out` sampled at the end of CDR.
- `vji_tck`, output, 1: generated test clock.
- `vji_tdi`, output, 1: serial data to the responder.
- `vji_tdo`, input, 1: serial data from the responder.
- `vji_ir_in`, output, IR_WIDTH: virtual IR.
- `vji_ir_out`, input, IR_WIDTH: responder IR status.
- `vji_uir`, `vji_cdr`, `vji_sdr`, `vji_udr`, `vji_rti`: output, 1 each; virtual TAP state strobes.

## Operation
- A `tck` period is 2·TCK_DIV `clk` cycles: low for the first TCK_DIV cycles, high for the last TCK_DIV cycles.
- A "slot" is one `tck` period. All strobes, `vji_tdi` and `vji_ir_in` change only at a slot start, which is the falling edge of `tck`.
- `tck` toggles only outside IDLE. In IDLE it is held low.
- States and slot counts:
  - IDLE: `vji_rti`=1, `cmd_ready`=1.
  - UIR, 1 slot: `vji_ir_in`=`cmd_ir`, `vji_uir`=1.
  - CDR, 1 slot: `vji_cdr`=1. `rsp_ir_out` is latched in the last cycle of the slot.
  - SDR, DR_WIDTH slots: `vji_sdr`=1. In slot k, `vji_tdi` = `cmd_dr[k]`.
  - UDR, 1 slot: `vji_udr`=1.
  - RTI, 1 slot: `vji_rti`=1.
  - DONE: lasts one `clk` cycle, pulses `rsp_valid`, then returns to IDLE.
- Exactly one of uir/cdr/sdr/udr/rti is high at any time.
- `vji_ir_in` holds its last value after the scan; it is not cleared on return to IDLE.
- TDO capture: in the `clk` cycle in which `tck` goes high during SDR slot k, `vji_tdo` is registered into bit k of the shift register. `rsp_dr` updates only at DONE.
- `cmd_dr` and `cmd_ir` are registered on acceptance. Input changes afterwards have no effect.
- A command offered while busy is not accepted (`cmd_ready`=0); the initiator holds it.

## Timing
- Reset values:
  - `cmd_ready`=1, `rsp_valid`=0, `rsp_dr`=0, `rsp_ir_out`=0.
  - `vji_tck`=0, `vji_tdi`=0, `vji_ir_in`=0.
  - uir/cdr/sdr/udr=0, `vji_rti`=1. State is IDLE.
- Acceptance happens at the cycle-0 clock edge where `cmd_valid`&`cmd_ready` are both high. `cmd_ready` drops in cycle 1 and the UIR slot starts in cycle 1.
- Total scan length is (DR_WIDTH+4)·2·TCK_DIV cycles. `rsp_valid` is high in cycle (DR_WIDTH+4)·2·TCK_DIV+1, which is 337 for the defaults.
- `cmd_ready` returns to 1 in the cycle after `rsp_valid`. A back-to-back command can be accepted in that cycle.
- Asserting `reset_n`=0 mid-scan immediately forces all outputs to their reset values:
  - The partial `rsp_dr` is discarded.
  - No `rsp_valid` is emitted.
- `vji_tdi` is stable for the whole slot, so it is stable around every rising `tck` edge.

## Structure
- Shared package `vjtag_pkg`:
  - state enum (IDLE, UIR, CDR, SDR, UDR, RTI, DONE);
  - default constants DR_WIDTH=38 and IR_WIDTH=2.
- Sub-module `vjtag_tck_gen`:
  - half-period counter;
  - outputs `tck`, a `slot_start` pulse (falling edge) and a `rise` pulse;
  - enabled only when not in IDLE.
- Top level: FSM, slot counter (ceil(log2 DR_WIDTH) bits, wraps to 0 on leaving SDR), TX and RX shift registers.

## Test plan
- Reset, then idle for 20 cycles -> `tck`=0, `rti`=1, `cmd_ready`=1, `rsp_valid` never high.
- Command with ir=2'b01, dr=38'h2A_5A5A_5A5A, and a responder that loops `tdo`=`tdi` delayed by one rising edge:
  - `rsp_valid` in cycle 337;
  - `rsp_dr` = input shifted left by 1 with bit0 = the initial tdo value (0);
  - `vji_ir_in`=01 from cycle 1.
- Strobe sequence check: `uir` high in cycles 1–8, `cdr` in 9–16, `sdr` in 17–320, `udr` in 321–328, `rti` in 329–336; exactly 42 rising `tck` edges.
- `cmd_valid` held high through a complete scan with a second command pending:
  - the second command is accepted in cycle 338;
  - the first command's `cmd_dr` is unaffected by the input changing in cycle 5.
- `reset_n` pulsed low during SDR slot 10 -> outputs take reset values asynchronously; no `rsp_valid`; a new command then completes normally.
- `vji_ir_out`=2'b10 during CDR -> `rsp_ir_out`=2'b10 at DONE.
